// File: rtl/cp0_regs.sv
// MIPS-style CP0 register block: Status, Cause, EPC, BadVAddr and registered interrupt request.
// Define CP0_TIMER_EN to build the Count/Compare timer and the Cause.TI interrupt source.
module cp0_regs #(
  parameter int COUNT_TICK_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [5:0]  hw_int,
  input  logic        exc_enter,
  input  logic        eret,
  input  logic        epc_wr,
  input  logic [31:0] epc_in,
  input  logic        cause_bd_wr,
  input  logic        cause_bd_in,
  input  logic        cause_exccode_wr,
  input  logic [4:0]  cause_exccode_in,
  input  logic        badvaddr_wr,
  input  logic [31:0] badvaddr_in,
  output logic [31:0] mfc0_rdata,
  output logic        status_exl,
  output logic [31:0] epc_out,
  output logic        int_req
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  logic [7:0]  status_im;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exccode;
  logic [31:0] epc;
  logic [31:0] badvaddr;

  logic wr_status, wr_cause, wr_epc, wr_badvaddr;

  assign wr_status   = mtc0_we && (cp0_addr == ADDR_STATUS);
  assign wr_cause    = mtc0_we && (cp0_addr == ADDR_CAUSE);
  assign wr_epc      = mtc0_we && (cp0_addr == ADDR_EPC);
  assign wr_badvaddr = mtc0_we && (cp0_addr == ADDR_BADVADDR);

  assign epc_out = epc;

  // Hardware exception updates win over a software write to the same field.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_im     <= 8'h00;
      status_ie     <= 1'b0;
      status_exl    <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ip      <= 8'h00;
      cause_exccode <= 5'd0;
      epc           <= 32'd0;
      badvaddr      <= 32'd0;
      int_req       <= 1'b0;
    end else begin
      if (wr_status) begin
        status_im <= mtc0_wdata[15:8];
        status_ie <= mtc0_wdata[0];
      end
      if (exc_enter)
        status_exl <= 1'b1;
      else if (eret)
        status_exl <= 1'b0;
      else if (wr_status)
        status_exl <= mtc0_wdata[1];

      cause_ip[7:2] <= {hw_int[5] | cause_ti, hw_int[4:0]};
      if (wr_cause)
        cause_ip[1:0] <= mtc0_wdata[9:8];
      if (cause_bd_wr)
        cause_bd <= cause_bd_in;
      if (cause_exccode_wr)
        cause_exccode <= cause_exccode_in;

      if (epc_wr)
        epc <= epc_in;
      else if (wr_epc)
        epc <= mtc0_wdata;

      if (badvaddr_wr)
        badvaddr <= badvaddr_in;
      else if (wr_badvaddr)
        badvaddr <= mtc0_wdata;

      int_req <= status_ie & ~status_exl & (|(cause_ip & status_im));
    end
  end

`ifdef CP0_TIMER_EN
  logic [COUNT_TICK_LOG2-1:0] tick;
  logic [31:0]                count;
  logic [31:0]                compare;
  logic                       wr_count, wr_compare;

  assign wr_count   = mtc0_we && (cp0_addr == ADDR_COUNT);
  assign wr_compare = mtc0_we && (cp0_addr == ADDR_COMPARE);

  // Count advances as the prescaler wraps; a software load leaves the prescaler phase alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick     <= '0;
      count    <= 32'd0;
      compare  <= 32'd0;
      cause_ti <= 1'b0;
    end else begin
      tick <= tick + COUNT_TICK_LOG2'(1);
      if (wr_count)
        count <= mtc0_wdata;
      else if (&tick)
        count <= count + 32'd1;
      if (wr_compare) begin
        compare  <= mtc0_wdata;
        cause_ti <= 1'b0;
      end else if ((compare != 32'd0) && (count == compare)) begin
        cause_ti <= 1'b1;
      end
    end
  end
`else
  assign cause_ti = 1'b0;
`endif

  always_comb begin
    mfc0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_BADVADDR: mfc0_rdata = badvaddr;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:    mfc0_rdata = count;
      ADDR_COMPARE:  mfc0_rdata = compare;
`endif
      ADDR_STATUS:   mfc0_rdata = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
      ADDR_CAUSE:    mfc0_rdata = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exccode, 2'b00};
      ADDR_EPC:      mfc0_rdata = epc;
      default:       mfc0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regs.sv
// Directed testbench for cp0_regs; timer checks build only when CP0_TIMER_EN is defined.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] mtc0_wdata;
  logic [5:0]  hw_int;
  logic        exc_enter;
  logic        eret;
  logic        epc_wr;
  logic [31:0] epc_in;
  logic        cause_bd_wr;
  logic        cause_bd_in;
  logic        cause_exccode_wr;
  logic [4:0]  cause_exccode_in;
  logic        badvaddr_wr;
  logic [31:0] badvaddr_in;
  logic [31:0] mfc0_rdata;
  logic        status_exl;
  logic [31:0] epc_out;
  logic        int_req;

  int total = 0;
  int bad = 0;

  cp0_regs #(.COUNT_TICK_LOG2(1)) dut (
    .clk(clk), .rst(rst), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_wdata(mtc0_wdata),
    .hw_int(hw_int), .exc_enter(exc_enter), .eret(eret), .epc_wr(epc_wr), .epc_in(epc_in),
    .cause_bd_wr(cause_bd_wr), .cause_bd_in(cause_bd_in), .cause_exccode_wr(cause_exccode_wr),
    .cause_exccode_in(cause_exccode_in), .badvaddr_wr(badvaddr_wr), .badvaddr_in(badvaddr_in),
    .mfc0_rdata(mfc0_rdata), .status_exl(status_exl), .epc_out(epc_out), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mtc0_we = 1'b0; mtc0_wdata = 32'd0;
    exc_enter = 1'b0; eret = 1'b0;
    epc_wr = 1'b0; epc_in = 32'd0;
    cause_bd_wr = 1'b0; cause_bd_in = 1'b0;
    cause_exccode_wr = 1'b0; cause_exccode_in = 5'd0;
    badvaddr_wr = 1'b0; badvaddr_in = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; cp0_addr = a; mtc0_wdata = d;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    cp0_addr = a;
    #1;
    v = mfc0_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; hw_int = 6'h3F;
    mtc0(5'd12, 32'hFFFF_FFFF);
    exc_enter = 1'b1; epc_wr = 1'b1; epc_in = 32'hDEAD_BEEF;
    badvaddr_wr = 1'b1; badvaddr_in = 32'h1234_5678;
    cause_bd_wr = 1'b1; cause_bd_in = 1'b1;
    cause_exccode_wr = 1'b1; cause_exccode_in = 5'h1F;
    step(); step();
    clear_inputs(); rst = 1'b0; hw_int = 6'd0;
    total++; rd(5'd12, v);
    if (v !== 32'h0040_0000) begin bad++; $display("[TB] FAIL reset_status got=%h exp=%h", v, 32'h0040_0000); end
    total++; rd(5'd13, v);
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL reset_cause got=%h exp=0", v); end
    total++; rd(5'd8, v);
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL reset_badvaddr got=%h exp=0", v); end
    total++;
    if (epc_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_epc got=%h exp=0", epc_out); end
    total++;
    if (status_exl !== 1'b0) begin bad++; $display("[TB] FAIL reset_exl got=%b exp=0", status_exl); end
    total++;
    if (int_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_int_req got=%b exp=0", int_req); end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    exc_enter = 1'b1; epc_wr = 1'b1; epc_in = 32'hBFC0_0100;
    cause_exccode_wr = 1'b1; cause_exccode_in = 5'h0C;
    mtc0(5'd14, 32'h0000_1234);
    #1;
    total++;
    if (epc_out !== 32'h0) begin bad++; $display("[TB] FAIL exc_no_bypass got=%h exp=0", epc_out); end
    step(); clear_inputs();
    total++;
    if (epc_out !== 32'hBFC0_0100) begin bad++; $display("[TB] FAIL exc_epc got=%h exp=%h", epc_out, 32'hBFC0_0100); end
    total++;
    if (status_exl !== 1'b1) begin bad++; $display("[TB] FAIL exc_exl got=%b exp=1", status_exl); end
    total++; rd(5'd13, v);
    if (v !== 32'h0000_0030) begin bad++; $display("[TB] FAIL exc_cause got=%h exp=%h", v, 32'h30); end
    total++; rd(5'd14, v);
    if (v !== 32'hBFC0_0100) begin bad++; $display("[TB] FAIL exc_epc_read got=%h exp=%h", v, 32'hBFC0_0100); end
  endtask

  task automatic test_hw_priority();
    logic [31:0] v;
    mtc0(5'd8, 32'h1111_2222); step(); clear_inputs();
    total++; rd(5'd8, v);
    if (v !== 32'h1111_2222) begin bad++; $display("[TB] FAIL sw_badvaddr got=%h exp=%h", v, 32'h1111_2222); end
    badvaddr_wr = 1'b1; badvaddr_in = 32'hCAFE_F00D; mtc0(5'd8, 32'h0000_0001);
    step(); clear_inputs();
    total++; rd(5'd8, v);
    if (v !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL hw_badvaddr got=%h exp=%h", v, 32'hCAFE_F00D); end
    cause_bd_wr = 1'b1; cause_bd_in = 1'b1; mtc0(5'd13, 32'hFFFF_FFFF);
    step(); clear_inputs();
    total++; rd(5'd13, v);
    if (v !== 32'h8000_0330) begin bad++; $display("[TB] FAIL cause_mask got=%h exp=%h", v, 32'h8000_0330); end
    mtc0(5'd13, 32'h0); step(); clear_inputs();
    total++; rd(5'd13, v);
    if (v !== 32'h8000_0030) begin bad++; $display("[TB] FAIL cause_ip_clear got=%h exp=%h", v, 32'h8000_0030); end
    mtc0(5'd14, 32'h0000_1234); step(); clear_inputs();
    total++;
    if (epc_out !== 32'h0000_1234) begin bad++; $display("[TB] FAIL sw_epc got=%h exp=%h", epc_out, 32'h1234); end
  endtask

  task automatic test_status_mask();
    logic [31:0] v;
    mtc0(5'd12, 32'hFFFF_FFFF); step(); clear_inputs();
    total++; rd(5'd12, v);
    if (v !== 32'h0040_FF03) begin bad++; $display("[TB] FAIL status_mask got=%h exp=%h", v, 32'h0040_FF03); end
  endtask

  task automatic test_eret();
    logic [31:0] v;
    exc_enter = 1'b1; eret = 1'b1; step(); clear_inputs();
    total++;
    if (status_exl !== 1'b1) begin bad++; $display("[TB] FAIL exc_eret_same got=%b exp=1", status_exl); end
    eret = 1'b1; step(); clear_inputs();
    total++;
    if (status_exl !== 1'b0) begin bad++; $display("[TB] FAIL eret_alone got=%b exp=0", status_exl); end
    total++; rd(5'd12, v);
    if (v !== 32'h0040_FF01) begin bad++; $display("[TB] FAIL eret_status got=%h exp=%h", v, 32'h0040_FF01); end
  endtask

  task automatic test_interrupt();
    logic [31:0] v;
    mtc0(5'd12, 32'h0000_0401); hw_int = 6'b000001;
    step(); clear_inputs();
    total++; rd(5'd13, v);
    if (v !== 32'h8000_0430) begin bad++; $display("[TB] FAIL int_ip10 got=%h exp=%h", v, 32'h8000_0430); end
    total++; rd(5'd12, v);
    if (v !== 32'h0040_0401) begin bad++; $display("[TB] FAIL int_status got=%h exp=%h", v, 32'h0040_0401); end
    total++;
    if (int_req !== 1'b0) begin bad++; $display("[TB] FAIL int_req_early got=%b exp=0", int_req); end
    step();
    total++;
    if (int_req !== 1'b1) begin bad++; $display("[TB] FAIL int_req_set got=%b exp=1", int_req); end
    exc_enter = 1'b1; step(); clear_inputs();
    total++;
    if (status_exl !== 1'b1) begin bad++; $display("[TB] FAIL int_exc_exl got=%b exp=1", status_exl); end
    step();
    total++;
    if (int_req !== 1'b0) begin bad++; $display("[TB] FAIL int_req_masked got=%b exp=0", int_req); end
  endtask

  task automatic test_reset_override();
    logic [31:0] v;
    eret = 1'b1; step(); clear_inputs(); step();
    total++;
    if (int_req !== 1'b1) begin bad++; $display("[TB] FAIL ovr_pending got=%b exp=1", int_req); end
    rst = 1'b1; mtc0(5'd12, 32'hFFFF_FFFF); exc_enter = 1'b1;
    epc_wr = 1'b1; epc_in = 32'h8000_0180;
    step(); clear_inputs(); rst = 1'b0; hw_int = 6'd0;
    total++;
    if (int_req !== 1'b0) begin bad++; $display("[TB] FAIL ovr_int_req got=%b exp=0", int_req); end
    total++;
    if (status_exl !== 1'b0) begin bad++; $display("[TB] FAIL ovr_exl got=%b exp=0", status_exl); end
    total++;
    if (epc_out !== 32'h0) begin bad++; $display("[TB] FAIL ovr_epc got=%h exp=0", epc_out); end
    total++; rd(5'd12, v);
    if (v !== 32'h0040_0000) begin bad++; $display("[TB] FAIL ovr_status got=%h exp=%h", v, 32'h0040_0000); end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    logic [31:0] v;
    rst = 1'b1; step();
    rst = 1'b0; mtc0(5'd9, 32'hFFFF_FFFE); step();
    mtc0(5'd11, 32'd5); step(); clear_inputs();
    total++; rd(5'd9, v);
    if (v !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL timer_count_inc got=%h exp=%h", v, 32'hFFFF_FFFF); end
    step(); step();
    total++; rd(5'd9, v);
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL timer_wrap got=%h exp=0", v); end
    for (int i = 0; i < 10; i++) step();
    total++; rd(5'd9, v);
    if (v !== 32'd5) begin bad++; $display("[TB] FAIL timer_count5 got=%h exp=5", v); end
    total++; rd(5'd13, v);
    if (v[30] !== 1'b0) begin bad++; $display("[TB] FAIL timer_ti_early got=%b exp=0", v[30]); end
    step();
    total++; rd(5'd13, v);
    if (v[30] !== 1'b1) begin bad++; $display("[TB] FAIL timer_ti_set got=%b exp=1", v[30]); end
    mtc0(5'd11, 32'd9); step(); clear_inputs();
    total++; rd(5'd13, v);
    if (v[30] !== 1'b0) begin bad++; $display("[TB] FAIL timer_ti_clear got=%b exp=0", v[30]); end
    total++; rd(5'd9, v);
    if (v !== 32'd6) begin bad++; $display("[TB] FAIL timer_count6 got=%h exp=6", v); end
    total++; rd(5'd11, v);
    if (v !== 32'd9) begin bad++; $display("[TB] FAIL timer_compare got=%h exp=9", v); end
  endtask
`else
  task automatic test_no_timer();
    logic [31:0] v;
    mtc0(5'd9, 32'h0000_0055); step(); clear_inputs();
    total++; rd(5'd9, v);
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL no_timer_count got=%h exp=0", v); end
    mtc0(5'd11, 32'd3); step(); clear_inputs();
    step(); step(); step();
    total++; rd(5'd11, v);
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL no_timer_compare got=%h exp=0", v); end
    total++; rd(5'd13, v);
    if (v[30] !== 1'b0) begin bad++; $display("[TB] FAIL no_timer_ti got=%b exp=0", v[30]); end
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b0; cp0_addr = 5'd0; hw_int = 6'd0;
    test_reset();
    test_exception();
    test_hw_priority();
    test_status_mask();
    test_eret();
    test_interrupt();
    test_reset_override();
`ifdef CP0_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 SHALL have parameter COUNT_TICK_LOG2, default 1; Count increments once every 2^COUNT_TICK_LOG2 clk cycles.
REQ-002 SHALL have clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have mtc0_we  in  1  software register write strobe.
REQ-005 SHALL have cp0_addr  in  5  register number for mtc0/mfc0: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
REQ-006 SHALL have mtc0_wdata  in  32  software write data.
REQ-007 SHALL have hw_int  in  6  level hardware interrupt lines.
REQ-008 SHALL have exc_enter  in  1  exception entry; sets Status.EXL.
REQ-009 SHALL have eret  in  1  exception return; clears Status.EXL.
REQ-010 SHALL have epc_wr, epc_in  in  1, 32  EPC update.
REQ-011 SHALL have cause_bd_wr, cause_bd_in  in  1, 1  Cause.BD update.
REQ-012 SHALL have cause_exccode_wr, cause_exccode_in  in  1, 5  Cause.ExcCode update.
REQ-013 SHALL have badvaddr_wr, badvaddr_in  in  1, 32  BadVAddr update.
REQ-014 SHALL have mfc0_rdata  out  32  combinational read of register at cp0_addr; unlisted addresses read 0.
REQ-015 SHALL have status_exl, epc_out  out  1, 32  current Status.EXL and EPC.
REQ-016 SHALL have int_req  out  1  registered pending-interrupt request.

Function
REQ-017 SHALL implement Status bits IM[15:8], EXL[1], IE[0] writable by mtc0, BEV[22] read-only 1; all other bits read 0.
REQ-018 SHALL implement Cause BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[9:8] writable by mtc0.
REQ-019 SHALL register hw_int into Cause.IP[15:10] every cycle, with IP[15] = hw_int[5] OR Cause.TI.
REQ-020 SHALL write EPC and BadVAddr fully by mtc0; Count and Compare fully by mtc0.
REQ-021 SHALL give hardware writes (exc_enter, epc_wr, cause_*_wr, badvaddr_wr) priority over an mtc0_we to the same register in the same cycle.
REQ-022 SHALL keep EXL=1 when exc_enter and eret assert together.
REQ-023 SHALL make every write visible on mfc0_rdata/status_exl/epc_out the cycle after the edge; no same-cycle bypass.
REQ-024 SHALL increment Count by 1 modulo 2^32 when a free-running tick counter of width COUNT_TICK_LOG2 wraps to 0; mtc0 to Count loads the value and does not disturb the tick counter.
REQ-025 SHALL set Cause.TI on the edge after Count equals Compare (nonzero Compare only) and hold it until an mtc0 write to Compare, which clears it.
REQ-026 SHALL drive int_req = IE AND NOT EXL AND OR(IP[15:8] AND IM[15:8]), registered one cycle.

Reset
REQ-027 SHALL on rst: Status = 0x0040_0000, Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0, tick counter = 0, int_req = 0.
REQ-028 SHALL let rst override every simultaneous write, including during a pending interrupt.

Configuration
REQ-029 SHALL with CP0_TIMER_EN defined implement Count, Compare, TI per REQ-024/025.
REQ-030 SHALL without CP0_TIMER_EN omit Count/Compare/tick logic: addresses 9 and 11 read 0, writes ignored, TI constant 0.

Verification
REQ-031 SHALL cover: rst, then read 12 -> 0x0040_0000; read 13 -> 0.
REQ-032 SHALL cover: exc_enter=1, epc_wr=1 epc_in=0xBFC0_0100, cause_exccode_wr=1 code=0x0C, same-cycle mtc0 EPC=0x1234 -> next cycle EPC=0xBFC0_0100, EXL=1, Cause[6:2]=0x0C.
REQ-033 SHALL cover: mtc0 Status=0x0000_0401, hw_int=6'b000001 -> IP[10]=1 after 1 cycle, int_req=1 after 2; then exc_enter -> int_req=0 after 1 cycle.
REQ-034 SHALL cover (CP0_TIMER_EN, COUNT_TICK_LOG2=1): Count=0xFFFF_FFFE, Compare=5 -> Count wraps to 0; TI sets when Count reaches 5; mtc0 Compare=9 clears TI.
REQ-035 SHALL cover: exc_enter and eret same cycle -> EXL=1; eret alone next -> EXL=0.
REQ-036 SHALL cover: without CP0_TIMER_EN, mtc0 Count=0x55 -> address 9 reads 0.
